// File: rtl/core_pkg.sv
// core_pkg: shared widths, register-index types and the writeback-hit helper.
package core_pkg;
    localparam int XLEN = 64;
    localparam int NREG = 32;
    typedef logic [4:0]      reg_addr_t;
    typedef logic [XLEN-1:0] xdata_t;
    function automatic logic wb_hits(input logic wb_valid, input reg_addr_t wb_addr, input reg_addr_t r);
        return wb_valid && (wb_addr == r) && (r != '0);
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-writeback bit per register with set-over-clear priority;
// busy lookups are masked by a writeback landing in the same cycle.
module reg_scoreboard
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            set_en,
    input  reg_addr_t       set_addr,
    input  logic            wb_valid,
    input  reg_addr_t       wb_addr,
    input  reg_addr_t       rs1,
    input  reg_addr_t       rs2,
    input  reg_addr_t       rd,
    output logic            busy_rs1,
    output logic            busy_rs2,
    output logic            busy_rd,
    output logic [NREG-1:0] pending
);
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_next;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (set_en) w_set[set_addr] = 1'b1;
        if (wb_valid) w_clr[wb_addr] = 1'b1;
        w_next = ((r_pending & ~w_clr) | w_set) & {{(NREG-1){1'b1}}, 1'b0};
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) r_pending <= '0;
        else     r_pending <= w_next;

    assign busy_rs1 = r_pending[rs1] && !wb_hits(wb_valid, wb_addr, rs1);
    assign busy_rs2 = r_pending[rs2] && !wb_hits(wb_valid, wb_addr, rs2);
    assign busy_rd  = r_pending[rd]  && !wb_hits(wb_valid, wb_addr, rd);
    assign pending  = r_pending;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage; reads both sources with writeback forwarding,
// stalls RAW/WAW hazards via the scoreboard and registers the instruction for execute.
module operand_fetch
    import core_pkg::*;
#(
    parameter int OP_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] in_op,
    input  reg_addr_t       in_rs1,
    input  reg_addr_t       in_rs2,
    input  logic            in_use_rs1,
    input  logic            in_use_rs2,
    input  reg_addr_t       in_rd,
    input  logic            in_rd_we,
    output reg_addr_t       rf_rd_addr_0,
    output reg_addr_t       rf_rd_addr_1,
    input  xdata_t          rf_rd_data_0,
    input  xdata_t          rf_rd_data_1,
    input  logic            wb_valid,
    input  reg_addr_t       wb_addr,
    input  xdata_t          wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] out_op,
    output xdata_t          out_rs1_data,
    output xdata_t          out_rs2_data,
    output reg_addr_t       out_rd,
    output logic            out_rd_we,
    output logic [NREG-1:0] sb_pending
);
    logic            w_busy_rs1;
    logic            w_busy_rs2;
    logic            w_busy_rd;
    logic            w_hazard;
    logic            w_accept;
    logic            w_sb_set;
    xdata_t          w_op_a;
    xdata_t          w_op_b;
    logic            r_out_valid;
    logic [OP_W-1:0] r_out_op;
    xdata_t          r_out_rs1_data;
    xdata_t          r_out_rs2_data;
    reg_addr_t       r_out_rd;
    logic            r_out_rd_we;

    assign rf_rd_addr_0 = in_rs1;
    assign rf_rd_addr_1 = in_rs2;

    // The register file only shows a write after the edge, so forward it here.
    assign w_op_a = (in_rs1 == '0) ? '0 : (wb_valid && wb_addr == in_rs1) ? wb_data : rf_rd_data_0;
    assign w_op_b = (in_rs2 == '0) ? '0 : (wb_valid && wb_addr == in_rs2) ? wb_data : rf_rd_data_1;

    assign w_hazard = (in_use_rs1 && w_busy_rs1) || (in_use_rs2 && w_busy_rs2) || (in_rd_we && w_busy_rd);
    assign in_ready = (!r_out_valid || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;
    assign w_sb_set = w_accept && in_rd_we && (in_rd != '0);

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_sb_set),
        .set_addr (in_rd),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rd       (in_rd),
        .busy_rs1 (w_busy_rs1),
        .busy_rs2 (w_busy_rs2),
        .busy_rd  (w_busy_rd),
        .pending  (sb_pending)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid    <= 1'b0;
            r_out_op       <= '0;
            r_out_rs1_data <= '0;
            r_out_rs2_data <= '0;
            r_out_rd       <= '0;
            r_out_rd_we    <= 1'b0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_op       <= in_op;
            r_out_rs1_data <= w_op_a;
            r_out_rs2_data <= w_op_b;
            r_out_rd       <= in_rd;
            r_out_rd_we    <= in_rd_we;
        end else if (out_ready) begin
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_op       = r_out_op;
    assign out_rs1_data = r_out_rs1_data;
    assign out_rs2_data = r_out_rs2_data;
    assign out_rd       = r_out_rd;
    assign out_rd_we    = r_out_rd_we;
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage between decode and execute. Accepts one decoded instruction per cycle and drives the two read addresses of the 32×64 register file. Captures both source operands, with same-cycle writeback forwarding, into an output pipeline register. Tracks destination registers awaiting writeback in a scoreboard and stalls read-after-write and write-after-write hazards.

## Interface
- `XLEN`, 64: operand width.
- `OP_W`, 32: width of the opaque decoded-op payload carried alongside the operands.
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage accepts the instruction this cycle.
- `in_op` in OP_W: decoded-op payload, passed through unchanged.
- `in_rs1`, `in_rs2` in 5: source register indices.
- `in_use_rs1`, `in_use_rs2` in 1: the instruction reads that source.
- `in_rd` in 5: destination register index.
- `in_rd_we` in 1: the instruction writes `in_rd`.
- `rf_rd_addr_0`, `rf_rd_addr_1` out 5: register-file read addresses.
- `rf_rd_data_0`, `rf_rd_data_1` in XLEN: register-file read data, combinational.
- `wb_valid` in 1, `wb_addr` in 5, `wb_data` in XLEN: the writeback currently presented to the register-file write port.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `out_op` out OP_W, `out_rs1_data` out XLEN, `out_rs2_data` out XLEN, `out_rd` out 5, `out_rd_we` out 1: the registered instruction.
- `sb_pending` out 32: scoreboard bits, exposed for debug and verification.

## Operation
- **Read addresses.** `rf_rd_addr_0 = in_rs1` and `rf_rd_addr_1 = in_rs2`, purely combinational.
- **Operand select,** per source:
  - index 0 → 0;
  - otherwise, `wb_valid && wb_addr == rs` → `wb_data` (the register file does not show a write until the next edge);
  - otherwise the register-file data.
- **Writeback hit** for register r: `wb_valid && wb_addr == r && r != 0`.
- **RAW hazard:** `in_use_rsN && rsN != 0 && sb_pending[rsN]` and no writeback hit on rsN this cycle.
- **WAW hazard:** `in_rd_we && in_rd != 0 && sb_pending[in_rd]` and no writeback hit on `in_rd` this cycle.
- **Ready:** `in_ready = (!out_valid || out_ready) && !hazard`. `in_ready` depends combinationally on the `in_*` fields, `wb_*` and `out_ready`, and does not depend on `in_valid`.
- **Accept:** `accept = in_valid && in_ready`. On accept, all `out_*` fields load from the selected operands and inputs, and `out_valid` is set to 1.
- **Drain:** when `out_valid && out_ready && !accept`, `out_valid` is cleared to 0. Payload fields hold their value while `out_valid` is 0 or `out_ready` is 0.
- **Scoreboard update:**
  - set: accept with `in_rd_we && in_rd != 0` sets `sb_pending[in_rd]`;
  - clear: a writeback hit clears `sb_pending[wb_addr]`;
  - set and clear on the same index in the same cycle → the bit ends at 1.
  - Bit 0 is always 0.
  - A writeback to an index whose bit is already 0 changes nothing.
- **Accepted with `in_rd_we == 1` and `in_rd == 0`:** passed through, scoreboard untouched.

## Timing
- Accept-to-`out_valid` latency is one cycle. Full throughput is one instruction per cycle when there is no hazard and `out_ready` is held at 1.
- A writeback in cycle N:
  - is forwarded to an instruction accepted in cycle N;
  - releases a stall in that same cycle N.
- Reset values: `out_valid` 0, all `out_*` payload fields 0, `sb_pending` 0. `in_ready` is then a function of the inputs only.
- Reset asserted mid-operation discards the held instruction and all pending bits immediately, without waiting for a clock edge.
- No combinational path from `in_valid` to `in_ready`.

## Structure
- **Shared package** `core_pkg`:
  - constants: `XLEN`, `NREG = 32`;
  - typedefs: `reg_addr_t` (logic [4:0]), `xdata_t` (logic [XLEN-1:0]).
- **Sub-module** `reg_scoreboard`:
  - contents: the 32-bit pending vector, its set/clear logic with set priority, and bit 0 forced to 0;
  - lookups: `busy(rs1)`, `busy(rs2)`, `busy(rd)`, each with writeback-hit masking.
- Top level holds the operand muxes, hazard/ready logic and output register.

## Test plan
- **Basic read:** after reset, with register file x5 = 0x11, x6 = 0x22, send add rs1=5, rs2=6, rd=7 → next cycle `out_valid` = 1, `out_rs1_data` = 0x11, `out_rs2_data` = 0x22, `sb_pending[7]` = 1.
- **RAW stall and release:**
  - after the add above, send rs1=7 → `in_ready` = 0 while `sb_pending[7]` = 1;
  - drive `wb_valid` = 1, `wb_addr` = 7, `wb_data` = 0x33 in cycle N → accepted in N, `out_rs1_data` = 0x33, `sb_pending[7]` = 0 at N+1.
- **x0:** rs1=0, rs2=0, rd=0 with `rd_we` = 1 and `wb_valid` = 1, `wb_addr` = 0, `wb_data` = 0xFF → operands both 0, no stall, `sb_pending` stays 0.
- **Backpressure:** `out_ready` = 0 with `out_valid` = 1 → `in_ready` = 0 and the out fields stay stable for 5 cycles; raising `out_ready` drains the held instruction and accepts the next instruction in the same cycle.
- **Set/clear collision and WAW:**
  - while `sb_pending[9]` = 1, a writeback to x9 and an instruction with rd=9 in the same cycle → accepted, `sb_pending[9]` stays 1;
  - a further rd=9 instruction without a writeback stalls.
- **Async reset:** assert `rst` between clock edges with `out_valid` = 1 and `sb_pending` = 0x80 → both read 0 immediately, before the next edge.
